bc_level_apply: RTL and testbench
=================================

// Module: bc_level_apply
// PURPOSE
//  Receiving end of the control block's brightness/contrast pulse interface.
//  - Consumes binc/bdec/cinc/cdec single-cycle pulses and en[0].
//  - Holds saturating brightness-offset and contrast-gain levels.
//  - Commits level changes at the frame boundary.
//  - Applies both levels to the RGB pixel stream through a 3-stage pipeline
//    that sits in the video path after the camera/line buffer.
// PARAMETERS
//  BSTEP  16   brightness change per pulse (signed offset, pixel LSBs)
//  BMAX   255  brightness clamp; the level is held in [-BMAX, +BMAX]
//  CSTEP  2    contrast change per pulse (Q4.4 units; 16 = gain 1.0)
//  CMIN   0    lower contrast clamp (Q4.4)
//  CMAX   64   upper contrast clamp (Q4.4, gain 4.0)
//  CDEF   16   contrast value at reset (gain 1.0)
// PORTS
//  clk           in   1   pixel clock
//  rst           in   1   asynchronous reset, active-low
//  en_bc         in   1   en[0] from control; 1 = apply levels, 0 = pass-through
//  binc, bdec    in   1   brightness +/- request pulses (1 cycle each)
//  cinc, cdec    in   1   contrast +/- request pulses (1 cycle each)
//  x_count       in   13  current pixel column
//  y_count       in   13  current pixel row
//  in_valid      in   1   input pixel qualifier
//  r_in, g_in, b_in        in   8 each  input pixel
//  out_valid     out  1   in_valid delayed by 3 cycles
//  r_out, g_out, b_out     out  8 each  adjusted pixel
//  bright_lvl    out  9   active brightness level, signed two's complement
//  contrast_lvl  out  8   active contrast level, unsigned Q4.4
// BEHAVIOUR
//  Reset (rst=0, async):
//   - bright_lvl=0, contrast_lvl=CDEF; pending levels take the same values.
//   - out_valid=0; r_out/g_out/b_out=0; pipeline valid bits cleared.
//   - Reset mid-frame discards all in-flight pixels; out_valid stays 0 until
//     3 cycles after the first in_valid following reset release.
//  Pending levels (b_pend, c_pend), updated every clk:
//   - binc only: b_pend = min(b_pend + BSTEP, +BMAX).
//   - bdec only: b_pend = max(b_pend - BSTEP, -BMAX).
//   - Both or neither asserted: no change. Contrast uses CSTEP/CMIN/CMAX the
//     same way.
//   - Arithmetic is done 11 bits wide before clamping; no wrap-around.
//   - Pulses are accepted regardless of en_bc, because control already gates
//     them.
//  Commit:
//   - frame_start = (x_count==0 && y_count==0).
//   - On any clk with frame_start=1, bright_lvl<=b_pend and
//     contrast_lvl<=c_pend. Holding frame_start for several cycles is
//     harmless (commit is idempotent).
//   - A pulse on the same cycle as a commit updates pending only; the active
//     level picks it up at the next frame_start.
//  Pipeline (per channel, no backpressure, latency exactly 3):
//   - S1: d = {1'b0,pix} - 128 (signed 9b).
//   - S2: p = (d * contrast_lvl) >>> 4, arithmetic shift, 17b product;
//     then q = p + 128.
//   - S3: s = q + bright_lvl; clamp to [0,255] before output.
//   - Levels are sampled once at S2/S3 from the active registers. A commit
//     can therefore split a pixel already in flight; this is acceptable only
//     because commit occurs at pixel (0,0).
//   - en_bc=0: pixel data pass through unchanged with the same 3-cycle
//     latency. en_bc is sampled at S1 and carried with the pixel.
//   - The valid bit propagates with the data; r/g/b_out hold their last
//     value while out_valid=0.
// CONFIGURATION
//  BC_FRAME_SYNC_EN
//   - Defined: commit only at frame_start, as described above.
//   - Undefined: active levels track pending with 1-cycle delay
//     (bright_lvl <= b_pend every clk); x_count/y_count are unused.
// TESTING
//  1. Reset, en_bc=1, pixel (100,100,100) -> out (100,100,100),
//     out_valid 3 cycles after in_valid.
//  2. 3 binc pulses mid-frame -> bright_lvl stays 0 until x=y=0, then 48;
//     pixel 100 -> 148.
//  3. 20 bdec pulses -> bright_lvl clamps at -255; pixel 200 -> 0;
//     one binc then -> -239.
//  4. 8 cinc pulses -> contrast_lvl 32 (gain 2.0); pixel 192 -> 255 (sat);
//     pixel 100 -> 72; pixel 128 -> 128.
//  5. binc and bdec in same cycle -> levels unchanged. en_bc=0 with nonzero
//     levels: pixel 37 -> 37, latency 3.
//  6. Reset during a burst of valid pixels -> out_valid=0 immediately; levels
//     return to 0/CDEF. Without BC_FRAME_SYNC_EN, one binc -> bright_lvl=16
//     on the following clk.

Source files
------------

// File: rtl/bc_level_apply_if.sv
// rtl/bc_level_apply_if.sv - RGB pixel stream bundle (qualifier plus 8-bit R/G/B)
interface bc_level_apply_if;
  logic       valid;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (output valid, r, g, b);
  modport slave  (input  valid, r, g, b);
endinterface

// File: rtl/bc_level_apply.sv
// rtl/bc_level_apply.sv - brightness/contrast level holder and 3-stage pixel apply pipeline
// Define BC_FRAME_SYNC_EN to commit pending levels only at pixel (0,0); otherwise they track every clk.
module bc_level_apply #(
  parameter int BSTEP = 16,
  parameter int BMAX  = 255,
  parameter int CSTEP = 2,
  parameter int CMIN  = 0,
  parameter int CMAX  = 64,
  parameter int CDEF  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_bc,
  input  logic               binc,
  input  logic               bdec,
  input  logic               cinc,
  input  logic               cdec,
  input  logic [12:0]        x_count,
  input  logic [12:0]        y_count,
  bc_level_apply_if.slave    pix_in,
  bc_level_apply_if.master   pix_out,
  output logic signed [8:0]  bright_lvl,
  output logic [7:0]         contrast_lvl
);

`ifdef BC_FRAME_SYNC_EN
  localparam bit FRAME_SYNC = 1'b1;
`else
  localparam bit FRAME_SYNC = 1'b0;
`endif

  localparam logic signed [10:0] BSTEP_W = 11'(BSTEP);
  localparam logic signed [10:0] BMAX_W  = 11'(BMAX);
  localparam logic signed [10:0] BMIN_W  = -11'(BMAX);
  localparam logic signed [10:0] CSTEP_W = 11'(CSTEP);
  localparam logic signed [10:0] CMAX_W  = 11'(CMAX);
  localparam logic signed [10:0] CMIN_W  = 11'(CMIN);

  logic signed [8:0]  b_pend, b_nxt;
  logic [7:0]         c_pend, c_nxt;
  logic signed [10:0] b_up, b_dn, c_up, c_dn;
  logic               frame_start, commit;

  logic [2:0]         v;
  logic               en1, en2;
  logic [2:0][7:0]    pin;
  logic [2:0][8:0]    d1, d_nxt;
  logic [2:0][10:0]   q2, q_nxt;
  logic [2:0][7:0]    o3, o_nxt;
  logic signed [16:0] prod [3];
  logic signed [16:0] p    [3];
  logic signed [11:0] s    [3];

  assign frame_start = (x_count == 13'd0) && (y_count == 13'd0);
  assign commit      = FRAME_SYNC ? frame_start : 1'b1;

  // Widen to 11 bits so the step can never wrap before the clamp sees it.
  always_comb begin
    b_up  = {{2{b_pend[8]}}, b_pend} + BSTEP_W;
    b_dn  = {{2{b_pend[8]}}, b_pend} - BSTEP_W;
    c_up  = {3'b000, c_pend} + CSTEP_W;
    c_dn  = {3'b000, c_pend} - CSTEP_W;
    b_nxt = b_pend;
    c_nxt = c_pend;
    if (binc && !bdec)
      b_nxt = (b_up > BMAX_W) ? BMAX_W[8:0] : b_up[8:0];
    else if (bdec && !binc)
      b_nxt = (b_dn < BMIN_W) ? BMIN_W[8:0] : b_dn[8:0];
    if (cinc && !cdec)
      c_nxt = (c_up > CMAX_W) ? CMAX_W[7:0] : c_up[7:0];
    else if (cdec && !cinc)
      c_nxt = (c_dn < CMIN_W) ? CMIN_W[7:0] : c_dn[7:0];
  end

  assign pin = {pix_in.r, pix_in.g, pix_in.b};

  // Pass-through reuses d+128 so only one copy of each pixel is carried.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      d_nxt[i] = {1'b0, pin[i]} - 9'd128;
      prod[i]  = $signed(d1[i]) * $signed({1'b0, contrast_lvl});
      p[i]     = prod[i] >>> 4;
      q_nxt[i] = en1 ? (p[i][10:0] + 11'd128)
                     : ({{2{d1[i][8]}}, d1[i]} + 11'd128);
      s[i]     = $signed({q2[i][10], q2[i]})
               + $signed(en2 ? {{3{bright_lvl[8]}}, bright_lvl} : 12'd0);
      if (s[i] < 12'sd0)
        o_nxt[i] = 8'd0;
      else if (s[i] > 12'sd255)
        o_nxt[i] = 8'd255;
      else
        o_nxt[i] = s[i][7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_pend       <= '0;
      c_pend       <= 8'(CDEF);
      bright_lvl   <= '0;
      contrast_lvl <= 8'(CDEF);
      v            <= '0;
      en1          <= 1'b0;
      en2          <= 1'b0;
      d1           <= '0;
      q2           <= '0;
      o3           <= '0;
    end else begin
      b_pend <= b_nxt;
      c_pend <= c_nxt;
      if (commit) begin
        bright_lvl   <= b_pend;
        contrast_lvl <= c_pend;
      end
      v   <= {v[1:0], pix_in.valid};
      en1 <= en_bc;
      en2 <= en1;
      d1  <= d_nxt;
      q2  <= q_nxt;
      if (v[1])
        o3 <= o_nxt;
    end
  end

  assign pix_out.valid = v[2];
  assign pix_out.r     = o3[2];
  assign pix_out.g     = o3[1];
  assign pix_out.b     = o3[0];

endmodule

// File: tb/tb_bc_level_apply.sv
// tb/tb_bc_level_apply.sv - scoreboard bench for bc_level_apply
module tb_bc_level_apply;
  logic              clk;
  logic              rst;
  logic              en_bc;
  logic              binc, bdec, cinc, cdec;
  logic [12:0]       x_count, y_count;
  logic signed [8:0] bright_lvl;
  logic [7:0]        contrast_lvl;

  bc_level_apply_if pin ();
  bc_level_apply_if pout ();

  bc_level_apply dut (
    .clk          (clk),
    .rst          (rst),
    .en_bc        (en_bc),
    .binc         (binc),
    .bdec         (bdec),
    .cinc         (cinc),
    .cdec         (cdec),
    .x_count      (x_count),
    .y_count      (y_count),
    .pix_in       (pin.slave),
    .pix_out      (pout.master),
    .bright_lvl   (bright_lvl),
    .contrast_lvl (contrast_lvl)
  );

  typedef struct {
    int cyc;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   mb_pend  = 0;
  int   mc_pend  = 16;
  int   m_b      = 0;
  int   m_c      = 16;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_pix(input int pix, input bit en, input int bl, input int cl);
    int d, q, s;
    if (!en) return pix;
    d = pix - 128;
    q = ((d * cl) >>> 4) + 128;
    s = q + bl;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst && pout.valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", cyc - e.cyc, 3);
        check("r_out", int'(pout.r), e.r);
        check("g_out", int'(pout.g), e.g);
        check("b_out", int'(pout.b), e.b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int g, input int b);
    exp_t e;
    pin.valid = 1'b1;
    pin.r = 8'(r);
    pin.g = 8'(g);
    pin.b = 8'(b);
    e.cyc = cyc;
    e.r = model_pix(r, en_bc, m_b, m_c);
    e.g = model_pix(g, en_bc, m_b, m_c);
    e.b = model_pix(b, en_bc, m_b, m_c);
    sb.push_back(e);
    tick();
  endtask

  task automatic drain();
    pin.valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("drain", sb.size(), 0);
    tick();
  endtask

  task automatic pulse(input bit bi, input bit bd, input bit ci, input bit cd, input int n);
    for (int i = 0; i < n; i++) begin
      binc = bi; bdec = bd; cinc = ci; cdec = cd;
      if (bi && !bd) mb_pend = (mb_pend + 16 > 255) ? 255 : mb_pend + 16;
      if (bd && !bi) mb_pend = (mb_pend - 16 < -255) ? -255 : mb_pend - 16;
      if (ci && !cd) mc_pend = (mc_pend + 2 > 64) ? 64 : mc_pend + 2;
      if (cd && !ci) mc_pend = (mc_pend - 2 < 0) ? 0 : mc_pend - 2;
      tick();
    end
    binc = 0; bdec = 0; cinc = 0; cdec = 0;
  endtask

  task automatic commit();
`ifdef BC_FRAME_SYNC_EN
    x_count = 13'd0;
    y_count = 13'd0;
`endif
    tick();
    x_count = 13'd7;
    y_count = 13'd3;
    m_b = mb_pend;
    m_c = mc_pend;
    check("bright_lvl", int'(bright_lvl), m_b);
    check("contrast_lvl", int'(contrast_lvl), m_c);
  endtask

  initial begin
    rst = 1'b0;
    en_bc = 1'b1;
    binc = 0; bdec = 0; cinc = 0; cdec = 0;
    x_count = 13'd7;
    y_count = 13'd3;
    pin.valid = 1'b0;
    pin.r = 8'd0; pin.g = 8'd0; pin.b = 8'd0;
    repeat (3) tick();
    check("rst_out_valid", int'(pout.valid), 0);
    check("rst_r_out", int'(pout.r), 0);
    check("rst_bright", int'(bright_lvl), 0);
    check("rst_contrast", int'(contrast_lvl), 16);
    rst = 1'b1;
    tick();

    // unity gain, zero offset
    send(100, 100, 100);
    drain();

    // contrast gain 2.0
    pulse(0, 0, 1, 0, 8);
    commit();
    send(192, 100, 128);
    send(128, 0, 255);
    drain();
    pulse(0, 0, 0, 1, 8);
    commit();

    // brightness +48, commit deferred to frame start when synced
    pulse(1, 0, 0, 0, 3);
`ifdef BC_FRAME_SYNC_EN
    repeat (3) tick();
    check("bright_hold", int'(bright_lvl), 0);
`endif
    commit();
    send(100, 0, 250);
    drain();

    // saturate low then step back
    pulse(0, 1, 0, 0, 20);
    commit();
    send(200, 255, 10);
    drain();
    pulse(1, 0, 0, 0, 1);
    commit();

    // simultaneous inc/dec cancel
    pulse(1, 1, 1, 1, 2);
    commit();

    // pass-through with nonzero levels
    en_bc = 1'b0;
    send(37, 37, 37);
    for (int i = 0; i < 4; i++) send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    drain();
    en_bc = 1'b1;

    // mixed levels on random pixels
    pulse(1, 0, 1, 0, 18);
    commit();
    for (int i = 0; i < 6; i++) send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    drain();

    // contrast clamps at both ends
    pulse(0, 0, 1, 0, 30);
    commit();
    send(150, 90, 0);
    drain();
    pulse(0, 0, 0, 1, 40);
    commit();
    send(150, 90, 0);
    drain();

    // reset in the middle of a burst
    for (int i = 0; i < 4; i++) send(10 * i, 20 * i, 30 * i);
    check("burst_valid_seen", int'(pout.valid), 1);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", int'(pout.valid), 0);
    check("rst_mid_bright", int'(bright_lvl), 0);
    check("rst_mid_contrast", int'(contrast_lvl), 16);
    sb.delete();
    mb_pend = 0; mc_pend = 16; m_b = 0; m_c = 16;
    pin.valid = 1'b0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("post_rst_valid", int'(pout.valid), 0);
    send(60, 120, 180);
    drain();

`ifndef BC_FRAME_SYNC_EN
    // tracking mode: active level follows pending one clk later
    binc = 1'b1;
    tick();
    binc = 1'b0;
    check("track_before", int'(bright_lvl), 0);
    tick();
    check("track_after", int'(bright_lvl), 16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
